// File: rtl/ahb_lite_timer_irq_pkg.sv
// ahb_lite_timer_irq_pkg
// Shared constants for the AHB-Lite timer: register word offsets (HADDR[4:2]),
// CTRL bit positions, HTRANS encodings and the only accepted transfer size.
package ahb_lite_timer_irq_pkg;

  // Register offsets, as word indices taken from HADDR[4:2].
  localparam logic [2:0] TMR_CTRL_OFS     = 3'd0;  // 0x00
  localparam logic [2:0] TMR_VALUE_OFS    = 3'd1;  // 0x04
  localparam logic [2:0] TMR_RELOAD_OFS   = 3'd2;  // 0x08
  localparam logic [2:0] TMR_INTSTAT_OFS  = 3'd3;  // 0x0C
  localparam logic [2:0] TMR_PRESCALE_OFS = 3'd4;  // 0x10, prescaler build only

  // CTRL register bit positions.
  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_IRQ_EN_BIT      = 1;
  localparam int CTRL_AUTO_RELOAD_BIT = 2;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Registers are 32 bits wide; only word transfers reach them.
  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_lite_timer_irq_if.sv
// ahb_lite_timer_irq_if
// AHB-Lite bus bundle between a master (or interconnect) and the timer slave.
//   master modport: drives HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY;
//                   receives HREADYOUT, HRESP, HRDATA.
//   slave modport : the mirror image.
// HCLK / HRESETn are not part of the bundle; they are plain module ports.
interface ahb_lite_timer_irq_if #(
  parameter int ADDR_W = 12
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_timer_irq_slave_if.sv
// ahb_lite_slave_if
// AHB-Lite address-phase capture for a zero-wait-state slave. A transfer is
// accepted when HSEL & HREADY & HTRANS[1]; its direction, word offset and
// size check are held for the following data phase.
// Ports:
//   HCLK, HRESETn      clock, async active-low reset
//   hsel..hready       address-phase bus inputs
//   wr_en              write data phase completing this cycle (word size only)
//   rd_en              read data phase in progress this cycle
//   offset             registered HADDR[4:2]
//   size_ok            registered HSIZE == word
module ahb_lite_slave_if
  import ahb_lite_timer_irq_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready,
  output logic              wr_en,
  output logic              rd_en,
  output logic [2:0]        offset,
  output logic              size_ok
);

  logic accept;
  logic wr_pend;
  logic rd_pend;
  logic unused_haddr;

  assign accept = hsel & hready & htrans[1];

  // Only the word offset is decoded; the remaining address bits are ignored.
  assign unused_haddr = ^{haddr[ADDR_W-1:5], haddr[1:0]};

  // NOTE: clocked state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
      offset  <= '0;
      size_ok <= 1'b0;
    end else if (hready) begin
      wr_pend <= accept & hwrite;
      rd_pend <= accept & ~hwrite;
      if (accept) begin
        offset  <= haddr[4:2];
        size_ok <= (hsize == HSIZE_WORD);
      end
    end
  end

  // Narrow writes are dropped silently; reads ignore size.
  assign wr_en = wr_pend & size_ok & hready;
  assign rd_en = rd_pend;

endmodule

// File: rtl/ahb_lite_timer_irq.sv
// ahb_lite_timer_irq
// Zero-wait-state AHB-Lite timer: 32-bit down-counter with reload, one-shot or
// auto-reload mode and a level interrupt.
// Ports:
//   HCLK, HRESETn  clock, async active-low reset
//   bus            AHB-Lite slave bundle (HREADYOUT=1, HRESP=0 always)
//   TIMER_IRQ      INTSTAT & IRQ_EN, from flops only
// Registers: 0x00 CTRL{AUTO_RELOAD,IRQ_EN,ENABLE}, 0x04 VALUE, 0x08 RELOAD,
//            0x0C INTSTAT (W1C), 0x10 PRESCALE (prescaler build only).
// Build option: define AHB_TIMER_PRESCALER_EN to add the 8-bit prescaler;
// otherwise the counter ticks every cycle while enabled.
module ahb_lite_timer_irq
  import ahb_lite_timer_irq_pkg::*;
#(
  parameter int          ADDR_W       = 12,
  parameter logic [31:0] RESET_RELOAD = 32'h0000_0000
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_lite_timer_irq_if.slave  bus,
  output logic                 TIMER_IRQ
);

  logic        wr_en, rd_en, size_ok;
  logic [2:0]  offset;
  logic        ctrl_enable, ctrl_irq_en, ctrl_auto_reload;
  logic [31:0] value_q, value_d, reload_q;
  logic        intstat_q;
  logic        tick, hw_set, hw_stop;
  logic        wr_ctrl, wr_value, wr_reload, wr_intstat;
  logic [31:0] rdata;

  ahb_lite_slave_if #(.ADDR_W(ADDR_W)) u_slave_if (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .hsel    (bus.HSEL),
    .haddr   (bus.HADDR),
    .htrans  (bus.HTRANS),
    .hwrite  (bus.HWRITE),
    .hsize   (bus.HSIZE),
    .hready  (bus.HREADY),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .offset  (offset),
    .size_ok (size_ok)
  );

  assign wr_ctrl    = wr_en && (offset == TMR_CTRL_OFS);
  assign wr_value   = wr_en && (offset == TMR_VALUE_OFS);
  assign wr_reload  = wr_en && (offset == TMR_RELOAD_OFS);
  assign wr_intstat = wr_en && (offset == TMR_INTSTAT_OFS);

`ifdef AHB_TIMER_PRESCALER_EN
  logic [7:0] prescale_q;
  logic [7:0] pcnt_q;
  logic       wr_prescale;

  assign wr_prescale = wr_en && (offset == TMR_PRESCALE_OFS);
  assign tick        = ctrl_enable && (pcnt_q == prescale_q);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      if (wr_prescale) prescale_q <= bus.HWDATA[7:0];
      // Idle while disabled so a fresh enable always waits a full period.
      if (wr_prescale || !ctrl_enable || tick) pcnt_q <= '0;
      else                                     pcnt_q <= pcnt_q + 8'd1;
    end
  end
`else
  assign tick = ctrl_enable;
`endif

  // Counter next state. A VALUE write swallows that cycle's tick entirely,
  // so neither a decrement nor an interrupt can sneak in alongside it.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    value_d = value_q;
    hw_set  = 1'b0;
    hw_stop = 1'b0;
    if (wr_value) begin
      value_d = bus.HWDATA;
    end else if (tick) begin
      if (value_q > 32'd1) begin
        value_d = value_q - 32'd1;
      end else if (value_q == 32'd1) begin
        hw_set = 1'b1;
        if (ctrl_auto_reload) begin
          value_d = reload_q;  // pre-write RELOAD, even if it is being written now
        end else begin
          value_d = '0;
          hw_stop = 1'b1;
        end
      end else if (ctrl_auto_reload) begin
        value_d = reload_q;    // parked at zero: reload silently
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_enable      <= 1'b0;
      ctrl_irq_en      <= 1'b0;
      ctrl_auto_reload <= 1'b0;
      value_q          <= '0;
      reload_q         <= RESET_RELOAD;
      intstat_q        <= 1'b0;
    end else begin
      value_q <= value_d;
      if (wr_ctrl) begin
        ctrl_enable      <= bus.HWDATA[CTRL_ENABLE_BIT];
        ctrl_irq_en      <= bus.HWDATA[CTRL_IRQ_EN_BIT];
        ctrl_auto_reload <= bus.HWDATA[CTRL_AUTO_RELOAD_BIT];
      end else if (hw_stop) begin
        ctrl_enable <= 1'b0;
      end
      if (wr_reload) reload_q <= bus.HWDATA;
      // Hardware set beats a simultaneous W1C so no expiry is lost.
      if (hw_set)                          intstat_q <= 1'b1;
      else if (wr_intstat && bus.HWDATA[0]) intstat_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (offset)
        TMR_CTRL_OFS: begin
          rdata[CTRL_ENABLE_BIT]      = ctrl_enable;
          rdata[CTRL_IRQ_EN_BIT]      = ctrl_irq_en;
          rdata[CTRL_AUTO_RELOAD_BIT] = ctrl_auto_reload;
        end
        TMR_VALUE_OFS:    rdata = value_q;
        TMR_RELOAD_OFS:   rdata = reload_q;
        TMR_INTSTAT_OFS:  rdata[0] = intstat_q;
`ifdef AHB_TIMER_PRESCALER_EN
        TMR_PRESCALE_OFS: rdata[7:0] = prescale_q;
`endif
        default:          rdata = '0;
      endcase
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign TIMER_IRQ     = intstat_q & ctrl_irq_en;

  // Write acceptance is already folded into wr_en.
  logic unused_size_ok;
  assign unused_size_ok = size_ok;

endmodule

// File: tb/tb_ahb_lite_timer_irq.sv
// tb_ahb_lite_timer_irq
// Self-checking bench for ahb_lite_timer_irq. Transfers are queued with their
// expected data-phase results; a pipelined bus engine issues them back to
// back and compares HRDATA / TIMER_IRQ against the scoreboard at the negedge
// of each data phase. Define AHB_TIMER_PRESCALER_EN to also cover the prescaler.
module tb_ahb_lite_timer_irq;
  import ahb_lite_timer_irq_pkg::*;

  localparam logic [31:0] RST_RELOAD = 32'hCAFE_0005;
  localparam logic [11:0] A_CTRL     = 12'h000;
  localparam logic [11:0] A_VALUE    = 12'h004;
  localparam logic [11:0] A_RELOAD   = 12'h008;
  localparam logic [11:0] A_INTSTAT  = 12'h00C;
  localparam logic [11:0] A_PRESCALE = 12'h010;
  localparam logic [11:0] A_UNMAP    = 12'h018;

  typedef struct {
    logic        hsel;
    logic [1:0]  trans;
    logic        write;
    logic [11:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic        chk;
  } txn_t;

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  logic HCLK;
  logic HRESETn;
  logic timer_irq;
  int   n_checks = 0;
  int   n_fails  = 0;
  txn_t txn_q[$];
  exp_t exp_q[$];

  ahb_lite_timer_irq_if #(.ADDR_W(12)) bus ();

  ahb_lite_timer_irq #(.ADDR_W(12), .RESET_RELOAD(RST_RELOAD)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus.slave),
    .TIMER_IRQ (timer_irq)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_wr(input logic [11:0] addr, input logic [31:0] data,
                         input logic [2:0] size = HSIZE_WORD);
    txn_q.push_back('{hsel:1'b1, trans:HTRANS_NONSEQ, write:1'b1, addr:addr,
                      size:size, data:data, chk:1'b0});
  endtask

  // Write whose data phase also checks the interrupt line.
  task automatic push_wr_irq(input logic [11:0] addr, input logic [31:0] data,
                             input logic exp_irq);
    txn_q.push_back('{hsel:1'b1, trans:HTRANS_NONSEQ, write:1'b1, addr:addr,
                      size:HSIZE_WORD, data:data, chk:1'b1});
    exp_q.push_back('{chk_data:1'b0, data:32'h0, irq:exp_irq});
  endtask

  task automatic push_rd(input logic [11:0] addr, input logic [31:0] exp_data,
                         input logic exp_irq);
    txn_q.push_back('{hsel:1'b1, trans:HTRANS_NONSEQ, write:1'b0, addr:addr,
                      size:HSIZE_WORD, data:32'h0, chk:1'b1});
    exp_q.push_back('{chk_data:1'b1, data:exp_data, irq:exp_irq});
  endtask

  // Selected but IDLE: must not be treated as a transfer.
  task automatic push_idle_wr(input logic [11:0] addr, input logic [31:0] data);
    txn_q.push_back('{hsel:1'b1, trans:HTRANS_IDLE, write:1'b1, addr:addr,
                      size:HSIZE_WORD, data:data, chk:1'b0});
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0;
    bus.HADDR  = '0;
    bus.HSIZE  = HSIZE_WORD;
    bus.HWDATA = '0;
    bus.HREADY = 1'b1;
  endtask

  // Issue every queued transfer back to back. Entered and left at 1 time unit
  // after a rising edge; returns after the last data phase has completed.
  task automatic run_bus(input string tag);
    txn_t cur, prev;
    exp_t e;
    logic have_cur, have_prev;
    int   idx;
    have_prev = 1'b0;
    have_cur  = 1'b0;
    idx       = 0;
    cur       = '{hsel:1'b0, trans:2'b00, write:1'b0, addr:12'h0, size:3'b0, data:32'h0, chk:1'b0};
    prev      = cur;
    while (txn_q.size() != 0 || have_prev) begin
      if (txn_q.size() != 0) begin
        cur        = txn_q.pop_front();
        have_cur   = 1'b1;
        bus.HSEL   = cur.hsel;
        bus.HTRANS = cur.trans;
        bus.HWRITE = cur.write;
        bus.HADDR  = cur.addr;
        bus.HSIZE  = cur.size;
      end else begin
        have_cur   = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
        bus.HADDR  = '0;
        bus.HSIZE  = HSIZE_WORD;
      end
      bus.HWDATA = have_prev ? prev.data : 32'h0;
      @(negedge HCLK);
      if (have_prev && prev.chk) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL %s[%0d] scoreboard: got no expectation, required one", tag, idx - 1);
        end else begin
          e = exp_q.pop_front();
          if (e.chk_data) begin
            n_checks++;
            if (bus.HRDATA !== e.data) begin
              n_fails++;
              $display("FAIL %s[%0d] hrdata: got %h expected %h", tag, idx - 1, bus.HRDATA, e.data);
            end
          end
          n_checks++;
          if (timer_irq !== e.irq) begin
            n_fails++;
            $display("FAIL %s[%0d] timer_irq: got %b expected %b", tag, idx - 1, timer_irq, e.irq);
          end
        end
      end
      @(posedge HCLK);
      #1;
      prev      = cur;
      have_prev = have_cur;
      idx++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL %s leftover: got %0d unconsumed expectations expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    bus_idle();
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    n_checks += 4;
    if (bus.HRDATA !== 32'h0) begin n_fails++; $display("FAIL por_hrdata: got %h expected 0", bus.HRDATA); end
    if (timer_irq !== 1'b0)   begin n_fails++; $display("FAIL por_irq: got %b expected 0", timer_irq); end
    if (bus.HREADYOUT !== 1'b1) begin n_fails++; $display("FAIL por_hreadyout: got %b expected 1", bus.HREADYOUT); end
    if (bus.HRESP !== 1'b0)   begin n_fails++; $display("FAIL por_hresp: got %b expected 0", bus.HRESP); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    push_rd(A_RELOAD, RST_RELOAD, 1'b0);
    push_rd(A_CTRL, 32'h0, 1'b0);
    push_rd(A_VALUE, 32'h0, 1'b0);
    push_rd(A_INTSTAT, 32'h0, 1'b0);
    run_bus("por_regs");

    // Build up state with an interrupt pending, then reset mid read.
    push_wr(A_RELOAD, 32'h0000_1111);
    push_wr(A_VALUE, 32'd1);
    push_wr(A_CTRL, 32'h3);
    push_rd(A_VALUE, 32'd1, 1'b0);
    push_rd(A_INTSTAT, 32'd1, 1'b1);
    run_bus("pre_reset");
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = 1'b0;
    bus.HADDR  = A_CTRL;
    @(posedge HCLK);
    #1;
    bus_idle();
    n_checks++;
    if (bus.HRDATA !== 32'h2) begin n_fails++; $display("FAIL mid_read_ctrl: got %h expected 2", bus.HRDATA); end
    #2;
    HRESETn = 1'b0;
    #1;
    n_checks += 4;
    if (bus.HRDATA !== 32'h0) begin n_fails++; $display("FAIL rst_hrdata: got %h expected 0", bus.HRDATA); end
    if (timer_irq !== 1'b0)   begin n_fails++; $display("FAIL rst_irq: got %b expected 0", timer_irq); end
    if (bus.HREADYOUT !== 1'b1) begin n_fails++; $display("FAIL rst_hreadyout: got %b expected 1", bus.HREADYOUT); end
    if (bus.HRESP !== 1'b0)   begin n_fails++; $display("FAIL rst_hresp: got %b expected 0", bus.HRESP); end
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    push_rd(A_RELOAD, RST_RELOAD, 1'b0);
    push_rd(A_CTRL, 32'h0, 1'b0);
    push_rd(A_INTSTAT, 32'h0, 1'b0);
    push_rd(A_VALUE, 32'h0, 1'b0);
    run_bus("post_reset");
  endtask

  task automatic test_one_shot();
    push_wr(A_VALUE, 32'd3);
    push_wr(A_CTRL, 32'h3);
    push_rd(A_VALUE, 32'd3, 1'b0);
    push_rd(A_VALUE, 32'd2, 1'b0);
    push_rd(A_VALUE, 32'd1, 1'b0);
    push_rd(A_VALUE, 32'd0, 1'b1);
    push_rd(A_VALUE, 32'd0, 1'b1);
    push_rd(A_CTRL, 32'h2, 1'b1);
    push_rd(A_INTSTAT, 32'h1, 1'b1);
    run_bus("one_shot");
  endtask

  task automatic test_auto_reload();
    push_wr(A_CTRL, 32'h0);
    push_wr(A_INTSTAT, 32'h1);
    push_rd(A_INTSTAT, 32'h0, 1'b0);
    run_bus("ar_clean");
    push_wr(A_RELOAD, 32'd2);
    push_wr(A_VALUE, 32'd1);
    push_wr(A_CTRL, 32'h7);
    push_rd(A_VALUE, 32'd1, 1'b0);
    push_rd(A_VALUE, 32'd2, 1'b1);
    push_rd(A_VALUE, 32'd1, 1'b1);
    push_rd(A_VALUE, 32'd2, 1'b1);
    push_rd(A_VALUE, 32'd1, 1'b1);
    run_bus("auto_reload");
    // Stop counting, then W1C: IRQ high in its data phase, low right after.
    push_wr(A_CTRL, 32'h6);
    push_wr_irq(A_INTSTAT, 32'h1, 1'b1);
    push_rd(A_INTSTAT, 32'h0, 1'b0);
    run_bus("w1c");
    // Parked at zero with auto-reload: reload without an interrupt.
    push_wr(A_CTRL, 32'h0);
    push_wr(A_RELOAD, 32'd5);
    push_wr(A_VALUE, 32'd0);
    push_wr(A_CTRL, 32'h5);
    push_rd(A_VALUE, 32'd0, 1'b0);
    push_rd(A_VALUE, 32'd5, 1'b0);
    push_rd(A_VALUE, 32'd4, 1'b0);
    push_rd(A_INTSTAT, 32'h0, 1'b0);
    push_wr(A_CTRL, 32'h0);
    run_bus("zero_reload");
  endtask

  task automatic test_collisions();
    push_wr(A_VALUE, 32'd100);
    push_wr(A_CTRL, 32'h1);
    push_wr(A_VALUE, 32'h10);
    push_rd(A_VALUE, 32'h10, 1'b0);
    push_rd(A_VALUE, 32'h0F, 1'b0);
    push_wr(A_CTRL, 32'h0);
    run_bus("value_vs_tick");
    push_wr(A_VALUE, 32'd2);
    push_wr(A_CTRL, 32'h1);
    push_rd(A_VALUE, 32'd2, 1'b0);
    push_wr(A_INTSTAT, 32'h1);
    push_rd(A_INTSTAT, 32'h1, 1'b0);
    push_rd(A_CTRL, 32'h0, 1'b0);
    push_wr(A_INTSTAT, 32'h1);
    push_rd(A_INTSTAT, 32'h0, 1'b0);
    run_bus("w1c_vs_set");
    push_wr(A_RELOAD, 32'd7);
    push_wr(A_VALUE, 32'd2);
    push_wr(A_CTRL, 32'h5);
    push_rd(A_VALUE, 32'd2, 1'b0);
    push_wr(A_RELOAD, 32'd9);
    push_rd(A_VALUE, 32'd7, 1'b0);
    push_rd(A_VALUE, 32'd6, 1'b0);
    push_rd(A_RELOAD, 32'd9, 1'b0);
    push_wr(A_CTRL, 32'h0);
    push_wr(A_INTSTAT, 32'h1);
    run_bus("reload_vs_write");
  endtask

  task automatic test_filtering();
    push_wr(A_RELOAD, 32'h55);
    push_wr(A_RELOAD, 32'hAA, 3'b000);
    push_rd(A_RELOAD, 32'h55, 1'b0);
    push_idle_wr(A_RELOAD, 32'h77);
    push_rd(A_RELOAD, 32'h55, 1'b0);
    push_wr(A_UNMAP, 32'hFFFF_FFFF);
    push_rd(A_UNMAP, 32'h0, 1'b0);
    push_rd(A_CTRL, 32'h0, 1'b0);
    push_wr(A_PRESCALE, 32'h5A);
`ifdef AHB_TIMER_PRESCALER_EN
    push_rd(A_PRESCALE, 32'h5A, 1'b0);
`else
    push_rd(A_PRESCALE, 32'h0, 1'b0);
`endif
    run_bus("filtering");
  endtask

`ifdef AHB_TIMER_PRESCALER_EN
  task automatic test_prescaler();
    push_wr(A_PRESCALE, 32'd3);
    push_wr(A_VALUE, 32'd2);
    push_wr(A_CTRL, 32'h3);
    for (int i = 0; i < 4; i++) push_rd(A_VALUE, 32'd2, 1'b0);
    for (int i = 0; i < 4; i++) push_rd(A_VALUE, 32'd1, 1'b0);
    push_rd(A_VALUE, 32'd0, 1'b1);
    push_rd(A_PRESCALE, 32'd3, 1'b1);
    run_bus("prescaler");
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_collisions();
    test_filtering();
`ifdef AHB_TIMER_PRESCALER_EN
    test_prescaler();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
